// File: rtl/counter_ctrl.sv
// Command-driven sequencer for a WIDTH-bit up-counter: start/pause/resume/stop,
// one-shot or periodic terminal, with registered status outputs.
module counter_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_load,
  input  logic              cmd_periodic,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              paused,
  output logic              done,
  output logic              cmd_err,
  output logic [PCNT_W-1:0] periods
);

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  localparam logic [PCNT_W-1:0] PCNT_MAX = {PCNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t             state_r, state_next_s;
  logic [WIDTH-1:0]   count_r, count_next_s;
  logic [WIDTH-1:0]   term_r, term_next_s;
  logic               periodic_r, periodic_next_s;
  logic [PCNT_W-1:0]  periods_r, periods_next_s;
  logic               done_r, done_next_s;
  logic               err_r, err_next_s;
  logic               busy_r, paused_r;

  // Next-state and datapath decode; a command always takes precedence over the terminal check
  always_comb begin
    state_next_s    = state_r;
    count_next_s    = count_r;
    term_next_s     = term_r;
    periodic_next_s = periodic_r;
    periods_next_s  = periods_r;
    done_next_s     = 1'b0;
    err_next_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_START) begin
            state_next_s    = ST_RUN;
            count_next_s    = {WIDTH{1'b0}};
            term_next_s     = cmd_load;
            periodic_next_s = cmd_periodic;
            periods_next_s  = {PCNT_W{1'b0}};
          end else begin
            err_next_s = 1'b1;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PAUSE: state_next_s = ST_HOLD;
            OP_STOP:  state_next_s = ST_IDLE;
            default:  err_next_s   = 1'b1;
          endcase
        end else if (count_r == term_r) begin
          done_next_s = 1'b1;
          if (periodic_r) begin
            count_next_s   = {WIDTH{1'b0}};
            periods_next_s = (periods_r == PCNT_MAX) ? periods_r : periods_r + PCNT_W'(1);
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          count_next_s = count_r + WIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RESUME: state_next_s = ST_RUN;
            OP_STOP:   state_next_s = ST_IDLE;
            default:   err_next_s   = 1'b1;
          endcase
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      count_r    <= {WIDTH{1'b0}};
      term_r     <= {WIDTH{1'b0}};
      periodic_r <= 1'b0;
      periods_r  <= {PCNT_W{1'b0}};
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      paused_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      count_r    <= count_next_s;
      term_r     <= term_next_s;
      periodic_r <= periodic_next_s;
      periods_r  <= periods_next_s;
      done_r     <= done_next_s;
      err_r      <= err_next_s;
      busy_r     <= (state_next_s != ST_IDLE);
      paused_r   <= (state_next_s == ST_HOLD);
    end
  end

  assign count   = count_r;
  assign busy    = busy_r;
  assign paused  = paused_r;
  assign done    = done_r;
  assign cmd_err = err_r;
  assign periods = periods_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: stimulus pushes model predictions, a monitor
// pops and compares one set of outputs after every rising edge.
module tb_counter_ctrl;

  localparam int WIDTH  = 4;
  localparam int PCNT_W = 8;
  localparam int PMAX   = (1 << PCNT_W) - 1;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_PAUSE  = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STOP   = 2'b11;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [WIDTH-1:0]  cmd_load = 4'd0;
  logic              cmd_periodic = 1'b0;
  logic [WIDTH-1:0]  count;
  logic              busy, paused, done, cmd_err;
  logic [PCNT_W-1:0] periods;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int count;
    int busy;
    int paused;
    int done;
    int err;
    int periods;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a counter that is either stopped, running or frozen
  bit m_active, m_held, m_per;
  int m_cnt, m_term, m_periods;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_load(cmd_load), .cmd_periodic(cmd_periodic), .count(count),
    .busy(busy), .paused(paused), .done(done), .cmd_err(cmd_err), .periods(periods)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_held = 1'b0; m_per = 1'b0;
    m_cnt = 0; m_term = 0; m_periods = 0;
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] op,
                       input logic [WIDTH-1:0] ld, input logic per);
    exp_t e;
    int d, er;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; cmd_load = ld; cmd_periodic = per;
    d = 0; er = 0;
    if (!r) begin
      model_reset();
    end else if (v) begin
      if (op == OP_START && !m_active) begin
        m_active = 1'b1; m_held = 1'b0; m_cnt = 0;
        m_term = int'(ld); m_per = per; m_periods = 0;
      end else if (op == OP_PAUSE && m_active && !m_held) begin
        m_held = 1'b1;
      end else if (op == OP_RESUME && m_active && m_held) begin
        m_held = 1'b0;
      end else if (op == OP_STOP && m_active) begin
        m_active = 1'b0; m_held = 1'b0;
      end else begin
        er = 1;
      end
    end else if (m_active && !m_held) begin
      if (m_cnt == m_term) begin
        d = 1;
        if (m_per) begin
          m_cnt = 0;
          if (m_periods < PMAX) m_periods++;
        end else begin
          m_active = 1'b0;
        end
      end else begin
        m_cnt++;
      end
    end
    e.count = m_cnt; e.busy = int'(m_active); e.paused = int'(m_held);
    e.done = d; e.err = er; e.periods = m_periods;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, OP_START, 4'd0, 1'b0);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [WIDTH-1:0] ld, input logic per);
    drive(1'b1, 1'b1, op, ld, per);
  endtask

  task automatic chk_reset_now(input string tag);
    chk({tag, "_count"},   32'(count),   32'(m_cnt));
    chk({tag, "_busy"},    32'(busy),    32'(m_active));
    chk({tag, "_paused"},  32'(paused),  32'(m_held));
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_err"},     32'(cmd_err), 32'd0);
    chk({tag, "_periods"}, 32'(periods), 32'(m_periods));
  endtask

  // Monitor: compare the outputs presented after each rising edge against the oldest prediction
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",   32'(count),   32'(e.count));
        chk("busy",    32'(busy),    32'(e.busy));
        chk("paused",  32'(paused),  32'(e.paused));
        chk("done",    32'(done),    32'(e.done));
        chk("cmd_err", 32'(cmd_err), 32'(e.err));
        chk("periods", 32'(periods), 32'(e.periods));
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stimulus
    model_reset();
    #2;
    chk_reset_now("por");
    drive(1'b0, 1'b1, OP_START, 4'd5, 1'b0);
    drive(1'b1, 1'b0, OP_START, 4'd0, 1'b0);

    // one-shot T=5
    cmd(OP_START, 4'd5, 1'b0); idle(8);
    // periodic T=3
    cmd(OP_START, 4'd3, 1'b1); idle(14); cmd(OP_STOP, 4'd0, 1'b0);
    // one-shot T=9 with a pause at count 4
    cmd(OP_START, 4'd9, 1'b0); idle(4); cmd(OP_PAUSE, 4'd0, 1'b0); idle(5);
    cmd(OP_RESUME, 4'd0, 1'b0); idle(8);
    // terminal collisions, periodic T=2
    cmd(OP_START, 4'd2, 1'b1); idle(2); cmd(OP_STOP, 4'd0, 1'b0); idle(2);
    cmd(OP_START, 4'd2, 1'b1); idle(2); cmd(OP_PAUSE, 4'd0, 1'b0); idle(3);
    cmd(OP_RESUME, 4'd0, 1'b0); idle(5); cmd(OP_STOP, 4'd0, 1'b0);
    // illegal commands and cmd_load changes while running
    cmd(OP_RESUME, 4'd0, 1'b0);
    cmd(OP_START, 4'd6, 1'b1); idle(2);
    cmd(OP_START, 4'd1, 1'b0); cmd(OP_PAUSE, 4'd0, 1'b0); cmd(OP_PAUSE, 4'd0, 1'b0);
    cmd(OP_RESUME, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      drive(1'b1, 1'b0, OP_START, WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    cmd(OP_STOP, 4'd0, 1'b0);
    // reset mid-run at count 7, periods 2
    cmd(OP_START, 4'd7, 1'b1); idle(23);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk_reset_now("midrst");
    drive(1'b0, 1'b1, OP_START, 4'd4, 1'b0);
    drive(1'b0, 1'b1, OP_STOP, 4'd0, 1'b0);
    drive(1'b1, 1'b1, OP_START, 4'd3, 1'b0); idle(6);
    // T=0 one-shot, T=0 periodic to saturation, T=max one-shot
    cmd(OP_START, 4'd0, 1'b0); idle(3);
    cmd(OP_START, 4'd0, 1'b1); idle(PMAX + 10); cmd(OP_STOP, 4'd0, 1'b0);
    cmd(OP_START, 4'd15, 1'b0); idle(18);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        cmd(2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else
        idle(1);
    end
    idle(2);
    @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
